// File: rtl/riscv_pkg.sv
// riscv_pkg -- shared RV32I data-memory definitions: funct3 codes, the
// responder FSM state type, the data-path width and the lane/extend helpers
// used by dmem_responder.
package riscv_pkg;

   localparam int XLEN = 32;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_WAIT = 2'b01,
      ST_RESP = 2'b10
   } dmem_state_e;

   // True for the five funct3 codes a load may carry.
   function automatic logic load_legal(input logic [2:0] f3);
      case (f3)
         F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: load_legal = 1'b1;
         default:                             load_legal = 1'b0;
      endcase
   endfunction

   // True for the three funct3 codes a store may carry.
   function automatic logic store_legal(input logic [2:0] f3);
      case (f3)
         F3_SB, F3_SH, F3_SW: store_legal = 1'b1;
         default:             store_legal = 1'b0;
      endcase
   endfunction

   // Lane offset of the access with the sub-size address bits dropped.
   function automatic logic [1:0] lane_offset(input logic [2:0] f3, input logic [1:0] a);
      case (f3[1:0])
         2'b00:   lane_offset = a;
         2'b01:   lane_offset = {a[1], 1'b0};
         default: lane_offset = 2'b00;
      endcase
   endfunction

   // Byte-write enables for a store of the given size at the given lane.
   function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
      case (f3[1:0])
         2'b00:   store_be = 4'b0001 << off;
         2'b01:   store_be = off[1] ? 4'b1100 : 4'b0011;
         2'b10:   store_be = 4'b1111;
         default: store_be = 4'b0000;
      endcase
   endfunction

   // Store data replicated into every lane so the enables pick the right copy.
   function automatic logic [XLEN-1:0] store_data(input logic [2:0] f3, input logic [XLEN-1:0] d);
      case (f3[1:0])
         2'b00:   store_data = {4{d[7:0]}};
         2'b01:   store_data = {2{d[15:0]}};
         default: store_data = d;
      endcase
   endfunction

   // Selects the addressed byte/halfword from a word and extends it.
   function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] w,
                                                   input logic [2:0] f3,
                                                   input logic [1:0] off);
      logic [XLEN-1:0] sh;
      sh = w >> {off, 3'b000};
      case (f3)
         F3_LB:   load_extend = {{24{sh[7]}}, sh[7:0]};
         F3_LH:   load_extend = {{16{sh[15]}}, sh[15:0]};
         F3_LW:   load_extend = w;
         F3_LBU:  load_extend = {24'h000000, sh[7:0]};
         F3_LHU:  load_extend = {16'h0000, sh[15:0]};
         default: load_extend = 32'h0000_0000;
      endcase
   endfunction

endpackage

// File: rtl/dmem_ram.sv
// dmem_ram -- DEPTH_WORDS x 32 data array with per-byte synchronous write
// and combinational read. Contents are never reset.
module dmem_ram
   import riscv_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int AW          = 8
) (
   input  logic            clock,
   input  logic [3:0]      we,
   input  logic [AW-1:0]   addr,
   input  logic [XLEN-1:0] wdata,
   output logic [XLEN-1:0] rdata
);

   logic [XLEN-1:0] mem_r [DEPTH_WORDS];

   // Byte-lane write on the rising edge; only enabled lanes change.
   always_ff @(posedge clock) begin
      for (int b = 0; b < 4; b++) begin
         if (we[b]) begin
            mem_r[addr][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   assign rdata = mem_r[addr];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder -- single-outstanding RV32I data-memory responder with a
// programmable number of wait states. The access (read or byte-enabled
// write) happens once, on the edge that enters RESP; the response is then
// held until the core takes it.
// Build option: DMEM_MISALIGN_CHECK_EN faults misaligned half/word accesses;
// without it the address is silently aligned down.
module dmem_responder
   import riscv_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        busy
);

   localparam int         AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

   dmem_state_e      state_r, state_next_s;
   logic [3:0]       cnt_r, cnt_next_s;
   logic             accept_s, enter_resp_s, rsp_done_s;

   logic             we_r;
   logic [2:0]       funct3_r;
   logic [31:0]      addr_r, wdata_r;

   logic             acc_we_s;
   logic [2:0]       acc_funct3_s;
   logic [31:0]      acc_addr_s, acc_wdata_s;
   logic [1:0]       acc_off_s;
   logic             illegal_s, oob_s, misalign_s, err_s;
   logic [3:0]       ram_we_s;
   logic [XLEN-1:0]  ram_rdata_s;

   logic             rsp_valid_r, rsp_err_r;
   logic [XLEN-1:0]  rsp_rdata_r;

   // State and wait counter registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r <= ST_IDLE;
         cnt_r   <= 4'd0;
      end else begin
         state_r <= state_next_s;
         cnt_r   <= cnt_next_s;
      end
   end

   // Next-state logic: accept in IDLE, count down in WAIT, hold in RESP.
   always_comb begin
      state_next_s = state_r;
      cnt_next_s   = cnt_r;
      accept_s     = 1'b0;
      enter_resp_s = 1'b0;
      rsp_done_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (req_valid) begin
               accept_s = 1'b1;
               if (WAIT_LOAD == 4'd0) begin
                  state_next_s = ST_RESP;
                  enter_resp_s = 1'b1;
                  cnt_next_s   = 4'd0;
               end else begin
                  state_next_s = ST_WAIT;
                  cnt_next_s   = WAIT_LOAD;
               end
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (cnt_r == 4'd0) begin
               state_next_s = ST_RESP;
               enter_resp_s = 1'b1;
            end else begin
               cnt_next_s = cnt_r - 4'd1;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_next_s = ST_IDLE;
               rsp_done_s   = 1'b1;
            end else begin
               state_next_s = ST_RESP;
            end
         end
         default: begin
            state_next_s = ST_IDLE;
            cnt_next_s   = 4'd0;
         end
      endcase
   end

   // Latch the request fields at acceptance.
   always_ff @(posedge clock) begin
      if (reset) begin
         we_r     <= 1'b0;
         funct3_r <= 3'b000;
         addr_r   <= 32'h0000_0000;
         wdata_r  <= 32'h0000_0000;
      end else if (accept_s) begin
         we_r     <= req_we;
         funct3_r <= req_funct3;
         addr_r   <= req_addr;
         wdata_r  <= req_wdata;
      end else begin
         we_r     <= we_r;
      end
   end

   // The access uses the live request on a zero-wait IDLE->RESP hop,
   // otherwise the latched copy.
   always_comb begin
      if (state_r == ST_IDLE) begin
         acc_we_s     = req_we;
         acc_funct3_s = req_funct3;
         acc_addr_s   = req_addr;
         acc_wdata_s  = req_wdata;
      end else begin
         acc_we_s     = we_r;
         acc_funct3_s = funct3_r;
         acc_addr_s   = addr_r;
         acc_wdata_s  = wdata_r;
      end
   end

`ifdef DMEM_MISALIGN_CHECK_EN
   // Halfword needs addr[0]=0, word needs addr[1:0]=0.
   always_comb begin
      misalign_s = 1'b0;
      case (acc_funct3_s[1:0])
         2'b01:   misalign_s = acc_addr_s[0];
         2'b10:   misalign_s = (acc_addr_s[1:0] != 2'b00);
         default: misalign_s = 1'b0;
      endcase
   end
`else
   assign misalign_s = 1'b0;
`endif

   // Fault decode, lane selection and write enables for the access.
   always_comb begin
      illegal_s = acc_we_s ? !store_legal(acc_funct3_s) : !load_legal(acc_funct3_s);
      oob_s     = ({2'b00, acc_addr_s[31:2]} >= 32'(DEPTH_WORDS));
      err_s     = illegal_s | oob_s | misalign_s;
      acc_off_s = lane_offset(acc_funct3_s, acc_addr_s[1:0]);
      if (enter_resp_s && acc_we_s && !err_s && !reset) begin
         ram_we_s = store_be(acc_funct3_s, acc_off_s);
      end else begin
         ram_we_s = 4'b0000;
      end
   end

   dmem_ram #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_ram (
      .clock (clock),
      .we    (ram_we_s),
      .addr  (acc_addr_s[AW+1:2]),
      .wdata (store_data(acc_funct3_s, acc_wdata_s)),
      .rdata (ram_rdata_s)
   );

   // Response registers: loaded on entry to RESP, cleared on handshake.
   always_ff @(posedge clock) begin
      if (reset) begin
         rsp_valid_r <= 1'b0;
         rsp_err_r   <= 1'b0;
         rsp_rdata_r <= 32'h0000_0000;
      end else if (enter_resp_s) begin
         rsp_valid_r <= 1'b1;
         rsp_err_r   <= err_s;
         rsp_rdata_r <= (acc_we_s || err_s) ? 32'h0000_0000
                                            : load_extend(ram_rdata_s, acc_funct3_s, acc_off_s);
      end else if (rsp_done_s) begin
         rsp_valid_r <= 1'b0;
         rsp_err_r   <= 1'b0;
         rsp_rdata_r <= 32'h0000_0000;
      end else begin
         rsp_valid_r <= rsp_valid_r;
      end
   end

   assign req_ready = (state_r == ST_IDLE);
   assign busy      = (state_r != ST_IDLE);
   assign rsp_valid = rsp_valid_r;
   assign rsp_err   = rsp_err_r;
   assign rsp_rdata = rsp_rdata_r;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder -- directed and randomized checks of dmem_responder
// (DEPTH_WORDS=256, WAIT_CYCLES=2) against a byte-level memory model.
module tb_dmem_responder;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        busy;

   int vectors = 0;
   int miscompares = 0;
   logic [31:0] model_mem [0:255];

   dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .busy(busy)
   );

   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Reference: computes the response from the access rules and updates the model.
   task automatic ref_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata, output logic err, output logic [31:0] rd);
      int size, off, idx;
      logic legal;
      logic [31:0] w, mask;
      size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      if (we) legal = (f3 <= 3'd2);
      else    legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      off = int'(addr % 32'd4);
      off = off - (off % size);
      err = !legal || ((addr >> 2) >= 32'd256);
`ifdef DMEM_MISALIGN_CHECK_EN
      if (size > 1 && (addr % size) != 0) err = 1'b1;
`endif
      rd = 32'h0;
      if (!err) begin
         idx = int'(addr >> 2);
         w = model_mem[idx];
         if (we) begin
            for (int i = 0; i < size; i++) w[8*(off+i) +: 8] = wdata[8*i +: 8];
            model_mem[idx] = w;
         end else begin
            mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*size)) - 32'd1);
            rd = (w >> (8*off)) & mask;
            if (!f3[2] && size < 4 && rd[8*size-1]) rd = rd | ~mask;
         end
      end
   endtask

   // One complete request/response, holding rsp_ready low for 'hold' cycles in RESP.
   task automatic transact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input int hold, input string tag,
                           output logic [31:0] got);
      logic e_err;
      logic [31:0] e_rd;
      int k;
      ref_access(we, f3, addr, wdata, e_err, e_rd);
      @(negedge clock);
      check({tag, " req_ready idle"}, {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
      @(posedge clock); #1;
      req_valid = 1'b0;
      k = 0;
      do begin
         @(negedge clock);
         k++;
      end while (rsp_valid !== 1'b1 && k < 20);
      check({tag, " latency"}, k, 32'd4);
      check({tag, " err"}, {31'd0, rsp_err}, {31'd0, e_err});
      check({tag, " rdata"}, rsp_rdata, e_rd);
      check({tag, " busy/ready in RESP"}, {30'd0, busy, req_ready}, 32'd2);
      got = rsp_rdata;
      for (int h = 0; h < hold; h++) begin
         @(negedge clock);
         check({tag, " held valid/busy/ready"}, {29'd0, rsp_valid, busy, req_ready}, 32'd6);
         check({tag, " held rdata"}, rsp_rdata, e_rd);
      end
      rsp_ready = 1'b1;
      @(posedge clock); #1;
      rsp_ready = 1'b0;
      @(negedge clock);
      check({tag, " after handshake valid/busy/ready"},
            {29'd0, rsp_valid, busy, req_ready}, 32'd1);
   endtask

   initial begin
      logic [31:0] got;
      logic [31:0] a;
      logic [2:0]  f;

      // Reset state.
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("reset outputs", {28'd0, rsp_valid, rsp_err, busy, req_ready}, 32'd1);
      check("reset rdata", rsp_rdata, 32'h0);
      reset = 1'b0;

      // Give the first 64 words known contents.
      for (int i = 0; i < 64; i++)
         transact(1'b1, 3'b010, 32'(i * 4), $urandom, 0, "init SW", got);

      // SW then LW.
      transact(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 0, "SW 0x10", got);
      transact(1'b0, 3'b010, 32'h10, 32'h0, 0, "LW 0x10", got);
      check("LW 0x10 literal", got, 32'hDEAD_BEEF);

      // Sign handling on 0x80FF7F01.
      transact(1'b1, 3'b010, 32'h20, 32'h80FF_7F01, 0, "SW 0x20", got);
      transact(1'b0, 3'b000, 32'h23, 32'h0, 0, "LB 0x23", got);
      check("LB 0x23 literal", got, 32'hFFFF_FF80);
      transact(1'b0, 3'b100, 32'h23, 32'h0, 0, "LBU 0x23", got);
      check("LBU 0x23 literal", got, 32'h0000_0080);
      transact(1'b0, 3'b001, 32'h20, 32'h0, 0, "LH 0x20", got);
      check("LH 0x20 literal", got, 32'h0000_7F01);
      transact(1'b0, 3'b101, 32'h22, 32'h0, 0, "LHU 0x22", got);
      check("LHU 0x22 literal", got, 32'h0000_80FF);

      // Byte / halfword stores merge into the word.
      transact(1'b1, 3'b000, 32'h21, 32'h0000_00AA, 0, "SB 0x21", got);
      transact(1'b1, 3'b001, 32'h22, 32'h1234_5566, 0, "SH 0x22", got);
      transact(1'b0, 3'b010, 32'h20, 32'h0, 0, "LW 0x20 merged", got);
      check("LW 0x20 merged literal", got, 32'h5566_AA01);

      // Backpressure for 5 cycles.
      transact(1'b0, 3'b010, 32'h10, 32'h0, 5, "backpressure LW", got);

      // Faults.
      transact(1'b0, 3'b010, 32'h0, 32'h0, 0, "LW 0x0 before", got);
      a = got;
      transact(1'b1, 3'b010, 32'h400, 32'h5A5A_5A5A, 0, "SW 0x400", got);
      transact(1'b0, 3'b010, 32'h0, 32'h0, 0, "LW 0x0 after", got);
      check("word 0 unchanged", got, a);
      transact(1'b0, 3'b011, 32'h10, 32'h0, 0, "load f3 011", got);
      transact(1'b1, 3'b100, 32'h14, 32'h1, 0, "store f3 100", got);
      transact(1'b1, 3'b010, 32'hFFFF_FFFC, 32'h1, 0, "SW top addr", got);
      transact(1'b0, 3'b010, 32'h12, 32'h0, 0, "LW 0x12", got);
      transact(1'b0, 3'b001, 32'h21, 32'h0, 0, "LH 0x21", got);

      // Reset while the store is waiting.
      transact(1'b1, 3'b010, 32'h30, 32'hCAFE_F00D, 0, "SW 0x30 prior", got);
      @(negedge clock);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
      req_addr = 32'h30; req_wdata = 32'h1234_5678;
      @(posedge clock); #1;
      req_valid = 1'b0;
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      check("after reset ready/busy/valid", {29'd0, rsp_valid, busy, req_ready}, 32'd1);
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         check("no response after reset", {29'd0, rsp_valid, busy, req_ready}, 32'd1);
      end
      transact(1'b0, 3'b010, 32'h30, 32'h0, 0, "LW 0x30 after reset", got);
      check("LW 0x30 prior contents", got, 32'hCAFE_F00D);

      // Randomized traffic.
      for (int n = 0; n < 80; n++) begin
         f = 3'($urandom % 8);
         if ($urandom % 8 == 0) a = 32'h400 + ($urandom % 256) * 4 + ($urandom % 4);
         else                   a = ($urandom % 64) * 4 + ($urandom % 4);
         transact(1'($urandom % 2), f, a, $urandom, int'($urandom % 3), "random", got);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Clocking SHALL be one clock; reset is synchronous and active-high.
REQ-002 Parameter DEPTH_WORDS, default 256, SHALL set the number of 32-bit memory words.
REQ-003 Parameter WAIT_CYCLES, default 2, SHALL set the added wait states per access (0..15).
REQ-004 Ports SHALL be, in order:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- req_valid  in  1  core presents a load/store request
- req_ready  out  1  responder can accept a request
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I access size/sign code
- req_addr  in  32  byte address
- req_wdata  in  32  store data (in the low bits)
- rsp_valid  out  1  response available
- rsp_ready  in  1  core accepts the response
- rsp_rdata  out  32  load result, already extended; 0 for stores and errors
- rsp_err  out  1  access fault for this response
- busy  out  1  a request is in flight (WAIT or RESP)

Function
REQ-005 The FSM SHALL have states IDLE, WAIT and RESP.
- In IDLE, req_ready = 1.
- In WAIT and RESP, req_ready = 0.
REQ-006 When req_valid & req_ready, the block SHALL latch we/funct3/addr/wdata and load the wait counter with WAIT_CYCLES.
- If WAIT_CYCLES = 0 it goes to RESP; otherwise it goes to WAIT.
REQ-007 In WAIT, the counter SHALL decrement each cycle and move to RESP in the cycle it reaches 0.
- Requirement: a request accepted at edge N gives rsp_valid high after edge N+1+WAIT_CYCLES.
REQ-008 The memory access (read or byte-enabled write) SHALL be performed exactly once, on the WAIT->RESP (or IDLE->RESP) transition.
REQ-009 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL stay stable until rsp_valid & rsp_ready, then the FSM returns to IDLE.
- No back-to-back bypass: at least one IDLE cycle between requests.
REQ-010 Loads SHALL decode funct3 as follows:
- 000 LB: sign-extend byte
- 001 LH: sign-extend halfword
- 010 LW: word
- 100 LBU: zero-extend byte
- 101 LHU: zero-extend halfword
- Byte/halfword lane is selected by addr[1:0].
REQ-011 Stores SHALL decode funct3 as follows:
- 000 SB: one byte lane at addr[1:0]
- 001 SH: two lanes
- 010 SW: four lanes
- Store data is replicated into the selected lanes.
REQ-012 An illegal funct3 (load 011/110/111, store other than 000/001/010) SHALL set rsp_err = 1, suppress any write, and return rsp_rdata = 0.
REQ-013 Word index addr[31:2] >= DEPTH_WORDS SHALL set rsp_err = 1, suppress the write, and return rsp_rdata = 0.
- Word index arithmetic is unsigned; no wrap-around into valid space.
REQ-014 A store response SHALL carry rsp_err per REQ-012/013/017 and rsp_rdata = 0.
REQ-015 busy SHALL be 1 exactly when the state is not IDLE.

Reset
REQ-016 When reset is sampled high, including mid-WAIT or mid-RESP:
- The FSM SHALL go to IDLE and the counter to 0.
- rsp_valid = 0, rsp_err = 0, rsp_rdata = 0; req_ready = 1 in the following cycle.
- A pending access that has not yet been performed is dropped.
- Memory contents are not cleared.

Configuration
REQ-017 Macro DMEM_MISALIGN_CHECK_EN SHALL select misalignment handling.
- Defined: a halfword access with addr[0] = 1, or a word access with addr[1:0] != 0, gives rsp_err = 1, no write, rsp_rdata = 0.
- Undefined: the low address bits below the access size are ignored (address aligned down) and rsp_err is never raised for alignment.

Structure
REQ-018 Shared package riscv_pkg SHALL hold:
- funct3 load/store constants (F3_LB..F3_SW)
- the dmem FSM state enum
- the width constant for the 32-bit data path
REQ-019 Storage SHALL be one sub-module, dmem_ram:
- DEPTH_WORDS x 32 synchronous-write array
- 4-bit byte-write enable
- combinational read
- instantiated once inside dmem_responder

Verification
REQ-020 SW then LW, WAIT_CYCLES = 2:
- Stimulus: SW addr 0x10, data 0xDEADBEEF, accepted at edge 0, then LW addr 0x10.
- Required: store rsp_valid after edge 3 with rsp_err = 0; load returns rsp_rdata = 0xDEADBEEF.
REQ-021 Byte load sign handling, word at 0x20 = 0x80FF7F01:
- LB 0x23 -> 0xFFFFFF80
- LBU 0x23 -> 0x00000080
- LH 0x20 -> 0x00007F01
- LHU 0x22 -> 0x000080FF
REQ-022 Response backpressure:
- Stimulus: hold rsp_ready = 0 for 5 cycles in RESP.
- Required: rsp_valid and rsp_rdata stay stable, req_ready = 0 and busy = 1 throughout; IDLE one cycle after rsp_ready = 1.
REQ-023 Faults:
- SW to addr 0x400 (DEPTH 256) -> rsp_err = 1, and a later LW of word 0 is unchanged.
- load funct3 = 011 -> rsp_err = 1, rsp_rdata = 0.
- With DMEM_MISALIGN_CHECK_EN defined, LW 0x12 -> rsp_err = 1; undefined, it returns the word at 0x10.
REQ-024 Reset mid-WAIT:
- Stimulus: SW 0x30 data 0x12345678 accepted, reset asserted one cycle later.
- Required: no response, req_ready = 1 after reset, and LW 0x30 returns the prior contents.
